// File: rtl/ff_fifo_pkg.sv
// Shared defaults and the entry layout for the bubble-stuffing FIFO.
package ff_fifo_pkg;
  localparam int FF_DATA_W     = 91;
  localparam int FF_DEPTH_LOG2 = 4;
  localparam int FF_AF_MARGIN  = 2;

  typedef struct packed {
    logic                 bubble;
    logic [FF_DATA_W-1:0] payload;
  } ff_entry_t;
endpackage

// File: rtl/ff_fifo_ram.sv
// Simple dual-port payload storage: synchronous write, registered enabled read.
module ff_fifo_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself stays uninitialised.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ff_stuff_fifo.sv
// FIFO whose rollover writes reserve a trailing bubble slot.
// Optional sticky error flags enabled by defining FF_FIFO_ERR_FLAGS_EN.
module ff_stuff_fifo
  import ff_fifo_pkg::*;
#(
  parameter int DATA_W     = FF_DATA_W,
  parameter int DEPTH_LOG2 = FF_DEPTH_LOG2,
  parameter int AF_MARGIN  = FF_AF_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  write_enable,
  input  logic                  rollover_write,
  input  logic                  read_req,
  output logic [DATA_W-1:0]     read_data,
  output logic                  rdata_valid,
  output logic                  rdata_bubble,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  wr_ready,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0]         wptr_reg, rptr_reg, level_w, free_w;
  logic [DEPTH-1:0]      tag_reg;
  logic [DEPTH_LOG2-1:0] waddr, baddr, raddr;
  logic                  wr_accept, rd_fire;
  logic                  rdata_valid_reg, rdata_bubble_reg;

  assign level_w     = wptr_reg - rptr_reg;
  assign free_w      = PW'(DEPTH) - level_w;
  assign fifo_empty  = (level_w == '0);
  assign fifo_full   = (level_w == PW'(DEPTH));
  assign wr_ready    = (free_w >= PW'(2));
  assign almost_full = (free_w <= PW'(AF_MARGIN));
  assign level       = level_w;

  // Acceptance uses pre-edge space only; a same-cycle read does not help.
  assign wr_accept = write_enable && (rollover_write ? wr_ready : !fifo_full);
  assign rd_fire   = read_req && !fifo_empty;

  assign waddr = wptr_reg[DEPTH_LOG2-1:0];
  assign baddr = waddr + DEPTH_LOG2'(1);
  assign raddr = rptr_reg[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      tag_reg          <= '0;
      rdata_valid_reg  <= 1'b0;
      rdata_bubble_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        tag_reg[waddr] <= 1'b0;
        if (rollover_write) begin
          tag_reg[baddr] <= 1'b1;
          wptr_reg       <= wptr_reg + PW'(2);
        end else begin
          wptr_reg <= wptr_reg + PW'(1);
        end
      end
      if (rd_fire) begin
        rptr_reg         <= rptr_reg + PW'(1);
        rdata_bubble_reg <= tag_reg[raddr];
      end
      rdata_valid_reg <= rd_fire;
    end
  end

  assign rdata_valid  = rdata_valid_reg;
  assign rdata_bubble = rdata_bubble_reg;

  // The bubble slot's payload is don't-care, so only the real payload hits RAM.
  ff_fifo_ram #(
    .W  (DATA_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept && !rst),
    .waddr (waddr),
    .wdata (write_data),
    .re    (rd_fire),
    .raddr (raddr),
    .rdata (read_data)
  );

`ifdef FF_FIFO_ERR_FLAGS_EN
  logic overflow_err_reg, underflow_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err_reg  <= 1'b0;
      underflow_err_reg <= 1'b0;
    end else begin
      if (write_enable && !wr_accept) overflow_err_reg  <= 1'b1;
      if (read_req && fifo_empty)     underflow_err_reg <= 1'b1;
    end
  end

  assign overflow_err  = overflow_err_reg;
  assign underflow_err = underflow_err_reg;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif
endmodule
